// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the cache CPU port among NUM_REQ requesters.
// One transaction in flight: grant, enable pulse, blank cycle, wait for ready/timeout, respond.
module cache_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         cpu_address,
    output logic [DATA_WIDTH-1:0]         cpu_write_data,
    output logic                          cpu_read_enable,
    output logic                          cpu_write_enable,
    input  logic [DATA_WIDTH-1:0]         cpu_read_data,
    input  logic                          cpu_ready,
    output logic                          busy,
    output logic [IDW-1:0]                grant_id
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BLANK, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        id_q, id_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  gnt_any;
    logic [IDW-1:0]        gnt_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Lowest valid index overall, overridden by the lowest valid at/after the pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) >= ptr_q)) gnt_idx = IDW'(i);
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        id_d             = id_q;
        write_d          = write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        cnt_d            = cnt_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        req_ready        = '0;
        rsp_valid        = '0;
        cpu_read_enable  = 1'b0;
        cpu_write_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    // Gated by rst so every output reads 0 while reset is held.
                    for (int i = 0; i < NUM_REQ; i++)
                        req_ready[i] = rst && (gnt_idx == IDW'(i));
                    state_d = S_ISSUE;
                    id_d    = gnt_idx;
                    write_d = req_write[gnt_idx];
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ptr_d   = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            S_ISSUE: begin
                cpu_read_enable  = !write_q;
                cpu_write_enable = write_q;
                state_d          = S_BLANK;
            end
            S_BLANK: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cpu_ready) begin
                    rdata_d = write_q ? '0 : cpu_read_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                for (int i = 0; i < NUM_REQ; i++)
                    rsp_valid[i] = (id_q == IDW'(i));
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign cpu_address    = addr_q;
    assign cpu_write_data = wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign grant_id       = id_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: transaction-age model checked every cycle,
// plus directed scenarios with literal expectations on grants and responses.
module tb_cache_port_arbiter;
    localparam int N = 4, AW = 16, DW = 32, TO = 8;

    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, cpu_write_data, cpu_read_data;
    logic            rsp_err, cpu_read_enable, cpu_write_enable, cpu_ready, busy;
    logic [AW-1:0]   cpu_address;
    logic [1:0]      grant_id;

    int tests = 0, fails = 0, cyc = 0;

    cache_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_read_enable(cpu_read_enable), .cpu_write_enable(cpu_write_enable),
        .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transaction is described by its age in cycles since grant.
    // Age 1 = enable cycle, age 2 = blank, age >= 3 = waiting for the cache.
    bit            m_busy, m_resp, m_wr;
    int            m_age, m_id, m_ptr, m_gid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_err;

    int            g_log[$];
    int            r_id[$], r_lat[$];
    logic [DW-1:0] r_data[$];
    logic          r_err[$];
    int            g_cyc, wr_pulses;

    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_rsp;
        int g;
        cyc++;
        if (!rst) begin
            m_busy = 0; m_resp = 0; m_age = 0; m_ptr = 0; m_gid = 0; m_wr = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
            check("rst_ctrl", {req_ready, rsp_valid, busy, cpu_read_enable, cpu_write_enable, grant_id}, '0);
            check("rst_addr", cpu_address, '0);
            check("rst_data", {rsp_rdata, cpu_write_data}, '0);
            check("rst_err", rsp_err, '0);
        end else begin
            e_ready = '0; e_rsp = '0; g = -1;
            if (!m_busy)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) e_ready[g] = 1'b1;
            if (m_resp) e_rsp[m_id] = 1'b1;
            check("req_ready", req_ready, e_ready);
            check("rsp_valid", rsp_valid, e_rsp);
            check("busy", busy, m_busy);
            check("rd_en", cpu_read_enable, m_busy && !m_resp && m_age == 1 && !m_wr);
            check("wr_en", cpu_write_enable, m_busy && !m_resp && m_age == 1 && m_wr);
            check("grant_id", grant_id, m_gid);
            check("cpu_address", cpu_address, m_addr);
            check("cpu_write_data", cpu_write_data, m_wdata);
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", rsp_err, m_err);

            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin g_log.push_back(i); g_cyc = cyc; end
                if (rsp_valid[i]) begin
                    r_id.push_back(i); r_data.push_back(rsp_rdata);
                    r_err.push_back(rsp_err); r_lat.push_back(cyc - g_cyc);
                end
            end
            if (cpu_write_enable) wr_pulses++;

            if (g >= 0) begin
                m_busy = 1; m_age = 1; m_id = g; m_gid = g; m_wr = req_write[g];
                m_addr = req_addr[g*AW +: AW]; m_wdata = req_wdata[g*DW +: DW];
                m_ptr = (g + 1) % N;
            end else if (m_resp) begin
                m_busy = 0; m_resp = 0;
            end else if (m_busy) begin
                if (m_age >= 3 && cpu_ready) begin
                    m_rdata = m_wr ? '0 : cpu_read_data; m_err = 1'b0; m_resp = 1;
                end else if (m_age >= 3 && m_age - 3 == TO - 1) begin
                    m_rdata = '0; m_err = 1'b1; m_resp = 1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // Cache stub: cpu_ready is high while 'since' (cycles after the enable) is in [lo,hi].
    int since = -1, lo = 100, hi = 100;
    bit hold_all = 0;

    task automatic step();
        logic [N-1:0] rr;
        @(negedge clk);
        rr = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~rr;
        if (hold_all) req_valid = '1;
        if (cpu_read_enable || cpu_write_enable) since = 0;
        else if (since >= 0) since++;
        cpu_ready     = (since >= lo && since <= hi);
        cpu_read_data = {16'hCAFE, 16'(since)};
        if (cyc > 5000) begin
            fails++;
            $display("FAIL watchdog: got %0d cycles, expected under 5000", cyc);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1);
        end
    endtask

    task automatic do_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (r_id.size() < n && k < 80) begin step(); k++; end
        check("rsp_count", r_id.size(), n);
    endtask

    initial begin
        int gs;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        cpu_ready = 1'b0; cpu_read_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // T2: all requesting, grants rotate 0,1,2,3 and wrap to 0.
        lo = 3; hi = 3;
        for (int i = 0; i < N; i++) do_req(i, 1'b0, AW'(16'h10 * i), '0);
        hold_all = 1;
        for (int k = 0; k < 200 && g_log.size() < 5; k++) step();
        hold_all = 0; req_valid = '0;
        wait_rsp(5);
        check("rr_g0", g_log[0], 0);
        check("rr_g1", g_log[1], 1);
        check("rr_g2", g_log[2], 2);
        check("rr_g3", g_log[3], 3);
        check("rr_g4", g_log[4], 0);

        // T1: single read, ready three cycles after the enable.
        do_req(0, 1'b0, 16'h0004, '0);
        wait_rsp(6);
        check("t1_id", r_id[5], 0);
        check("t1_data", r_data[5], 32'hCAFE0003);
        check("t1_err", r_err[5], 0);
        check("t1_lat", r_lat[5], 5);
        check("t1_addr", cpu_address, 16'h0004);

        // T3: write from requester 2.
        do_req(2, 1'b1, 16'h0100, 32'hDEADBEEF);
        wait_rsp(7);
        check("t3_id", r_id[6], 2);
        check("t3_data", r_data[6], 0);
        check("t3_err", r_err[6], 0);
        check("t3_wdata", cpu_write_data, 32'hDEADBEEF);
        check("t3_wr_pulses", wr_pulses, 1);

        // T4: timeout after 8 wait cycles; then ready on the 8th wait cycle wins.
        lo = 100; hi = 100;
        do_req(1, 1'b0, 16'h0200, '0);
        wait_rsp(8);
        check("t4a_err", r_err[7], 1);
        check("t4a_data", r_data[7], 0);
        check("t4a_lat", r_lat[7], 11);
        lo = 9; hi = 9;
        do_req(1, 1'b0, 16'h0204, '0);
        wait_rsp(9);
        check("t4b_err", r_err[8], 0);
        check("t4b_data", r_data[8], 32'hCAFE0009);
        check("t4b_lat", r_lat[8], 11);

        // T6: ready already high in the blank cycle; taken in the first wait cycle.
        lo = 1; hi = 2;
        do_req(3, 1'b0, 16'h0300, '0);
        wait_rsp(10);
        check("t6_lat", r_lat[9], 4);
        check("t6_data", r_data[9], 32'hCAFE0002);
        check("t6_err", r_err[9], 0);

        // T5: reset while waiting; outputs drop at once, pointer returns to 0.
        lo = 100; hi = 100;
        do_req(2, 1'b0, 16'h0400, '0);
        repeat (5) step();
        check("t5_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_ctrl", {busy, cpu_read_enable, cpu_write_enable, rsp_valid, req_ready}, '0);
        check("t5_async_addr", cpu_address, '0);
        check("t5_async_gid", grant_id, '0);
        repeat (2) step();
        rst = 1'b1;
        lo = 3; hi = 3;
        do_req(1, 1'b0, 16'h0500, '0);
        do_req(3, 1'b0, 16'h0600, '0);
        gs = g_log.size();
        step();
        check("t5_no_rsp", r_id.size(), 10);
        check("t5_first_grant_cnt", g_log.size(), gs + 1);
        if (g_log.size() > gs) check("t5_first_grant", g_log[gs], 1);
        wait_rsp(12);
        check("t5_rsp_a", r_id[10], 1);
        check("t5_rsp_b", r_id[11], 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
